// File: rtl/msi_wb_bfm_slave_core_if.sv
// Bus bundle for msi_wb_bfm_slave_core: Wishbone B3 slave port plus the
// per-beat request/response channel towards the local backend.
interface msi_wb_bfm_slave_core_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Wishbone side
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic [1:0]      wb_bte_i;
  logic [2:0]      wb_cti_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  // Backend handshake: req_valid stays high with stable req_* fields until
  // the backend raises rsp_valid for one cycle; rsp_dat/rsp_err/rsp_rty are
  // only meaningful in that cycle. There is no separate ready signal.
  logic            req_valid;
  logic            req_we;
  logic [AW-1:0]   req_adr;
  logic [DW-1:0]   req_dat;
  logic [DW/8-1:0] req_mask;
  logic            req_burst;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_dat;
  logic            rsp_err;
  logic            rsp_rty;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_bte_i, wb_cti_i,
    input  wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
    output req_valid, req_we, req_adr, req_dat, req_mask, req_burst,
    input  rsp_valid, rsp_dat, rsp_err, rsp_rty
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_bte_i, wb_cti_i,
    output wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
    input  req_valid, req_we, req_adr, req_dat, req_mask, req_burst,
    output rsp_valid, rsp_dat, rsp_err, rsp_rty
  );
endinterface

// File: rtl/msi_wb_bfm_slave_core.sv
// Wishbone B3 slave front-end: turns classic/burst cycles into per-beat backend
// requests. Define MSI_WB_BFM_SLAVE_RTY_EN to honour rsp_rty (else wb_rty_o=0).
module msi_wb_bfm_slave_core #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  msi_wb_bfm_slave_core_if.slave bus,
  output logic [1:0]             o_state
);
  localparam int SW      = DW / 8;
  localparam int ADR_LSB = $clog2(SW);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2} state_t;

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat;
  logic [DW-1:0] r_dat_o;
  logic [SW-1:0] r_sel;
  logic          r_we, r_burst, r_req_valid;
  logic          r_ack, r_err, r_rty;
  logic          w_go, w_cont, w_rty;
  logic [AW-1:0] w_inc, w_wrap_mask, w_adr_nx;

  assign w_go   = bus.wb_cyc_i & bus.wb_stb_i;
  assign w_cont = r_ack & r_burst & (bus.wb_cti_i != 3'b111) & w_go;

`ifdef MSI_WB_BFM_SLAVE_RTY_EN
  assign w_rty = bus.rsp_rty;
`else
  assign w_rty = 1'b0;
`endif

  // Wrap-N keeps every bit outside the wrap field; linear uses an all-ones
  // mask so the plain increment passes straight through.
  always_comb begin
    w_inc = r_adr + AW'(SW);
    case (bus.wb_bte_i)
      2'b01:   w_wrap_mask = AW'(3)  << ADR_LSB;
      2'b10:   w_wrap_mask = AW'(7)  << ADR_LSB;
      2'b11:   w_wrap_mask = AW'(15) << ADR_LSB;
      default: w_wrap_mask = '1;
    endcase
    if (bus.wb_cti_i == 3'b001) w_adr_nx = r_adr;
    else                        w_adr_nx = (r_adr & ~w_wrap_mask) | (w_inc & w_wrap_mask);
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_nx = REQ;
      REQ: begin
        if (!bus.wb_cyc_i)       w_state_nx = IDLE;
        else if (bus.rsp_valid)  w_state_nx = ACK;
      end
      ACK:     w_state_nx = w_cont ? REQ : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_burst     <= 1'b0;
      r_req_valid <= 1'b0;
      r_dat_o     <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rty       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rty <= 1'b0;
      case (r_state)
        IDLE: if (w_go) begin
          r_adr       <= bus.wb_adr_i;
          r_dat       <= bus.wb_dat_i;
          r_sel       <= bus.wb_sel_i;
          r_we        <= bus.wb_we_i;
          r_burst     <= (bus.wb_cti_i == 3'b001) || (bus.wb_cti_i == 3'b010);
          r_req_valid <= 1'b1;
        end
        REQ: begin
          if (!bus.wb_cyc_i) begin
            r_req_valid <= 1'b0;
          end else if (bus.rsp_valid) begin
            r_req_valid <= 1'b0;
            r_err       <= bus.rsp_err;
            r_rty       <= !bus.rsp_err & w_rty;
            r_ack       <= !bus.rsp_err & !w_rty;
            if (!r_we) r_dat_o <= bus.rsp_dat;
          end
        end
        ACK: if (w_cont) begin
          r_adr       <= w_adr_nx;
          r_dat       <= bus.wb_dat_i;
          r_sel       <= bus.wb_sel_i;
          r_req_valid <= 1'b1;
        end
        default: r_req_valid <= 1'b0;
      endcase
    end
  end

  assign bus.wb_dat_o  = r_dat_o;
  assign bus.wb_ack_o  = r_ack;
  assign bus.wb_err_o  = r_err;
`ifdef MSI_WB_BFM_SLAVE_RTY_EN
  assign bus.wb_rty_o  = r_rty;
`else
  assign bus.wb_rty_o  = 1'b0;
`endif
  assign bus.req_valid = r_req_valid;
  assign bus.req_we    = r_we;
  assign bus.req_adr   = r_adr;
  assign bus.req_dat   = r_dat;
  assign bus.req_mask  = r_sel;
  assign bus.req_burst = r_burst;
  assign o_state       = r_state;
endmodule

// File: tb/tb_msi_wb_bfm_slave_core.sv
// Directed bench for msi_wb_bfm_slave_core: classic, wrap and linear bursts,
// error/retry terminations, abort and mid-beat reset.
module tb_msi_wb_bfm_slave_core;
  logic       i_clk;
  logic       i_rst_n;
  logic [1:0] o_state;
  int         errors;
  int         checks;
  int         ack_cnt;
  logic [31:0] wrap_adr [4];
  logic [31:0] lin_dat  [4];
  logic [3:0]  lin_sel  [4];

  msi_wb_bfm_slave_core_if #(.AW(32), .DW(32)) bus ();

  msi_wb_bfm_slave_core #(.AW(32), .DW(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave),
    .o_state (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   64'(bus.wb_ack_o),  64'd0);
    chk({tag, "_err"},   64'(bus.wb_err_o),  64'd0);
    chk({tag, "_rty"},   64'(bus.wb_rty_o),  64'd0);
    chk({tag, "_rqv"},   64'(bus.req_valid), 64'd0);
    chk({tag, "_rqwe"},  64'(bus.req_we),    64'd0);
    chk({tag, "_rqbst"}, 64'(bus.req_burst), 64'd0);
    chk({tag, "_dato"},  64'(bus.wb_dat_o),  64'd0);
    chk({tag, "_rqadr"}, 64'(bus.req_adr),   64'd0);
    chk({tag, "_rqdat"}, 64'(bus.req_dat),   64'd0);
    chk({tag, "_rqmsk"}, 64'(bus.req_mask),  64'd0);
    chk({tag, "_state"}, 64'(o_state),       64'd0);
  endtask

  initial begin
    errors = 0; checks = 0; ack_cnt = 0;
    wrap_adr[0] = 32'h1C; wrap_adr[1] = 32'h10; wrap_adr[2] = 32'h14; wrap_adr[3] = 32'h18;
    lin_dat[0] = 32'h1111_0000; lin_dat[1] = 32'h2222_0001;
    lin_dat[2] = 32'h3333_0002; lin_dat[3] = 32'h4444_0003;
    lin_sel[0] = 4'hF; lin_sel[1] = 4'h3; lin_sel[2] = 4'hC; lin_sel[3] = 4'h1;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0; bus.wb_we_i = 1'b0;
    bus.wb_bte_i = '0; bus.wb_cti_i = '0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    bus.rsp_valid = 1'b0; bus.rsp_dat = '0; bus.rsp_err = 1'b0; bus.rsp_rty = 1'b0;
    i_rst_n = 1'b0;

    // reset values
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk_reset_vals("rst");
    i_rst_n = 1'b1;

    // classic write, backend responds immediately: req at cycle 1, ack at cycle 2
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 32'h10; bus.wb_dat_i = 32'hDEAD_BEEF; bus.wb_sel_i = 4'hF;
    bus.wb_cti_i = 3'b000; bus.rsp_valid = 1'b1;
    tick();
    chk("cw_rqv",  64'(bus.req_valid), 64'd1);
    chk("cw_we",   64'(bus.req_we),    64'd1);
    chk("cw_adr",  64'(bus.req_adr),   64'h10);
    chk("cw_msk",  64'(bus.req_mask),  64'hF);
    chk("cw_dat",  64'(bus.req_dat),   64'hDEAD_BEEF);
    chk("cw_bst",  64'(bus.req_burst), 64'd0);
    chk("cw_ack1", 64'(bus.wb_ack_o),  64'd0);
    tick();
    chk("cw_ack2", 64'(bus.wb_ack_o),  64'd1);
    chk("cw_err2", 64'(bus.wb_err_o),  64'd0);
    chk("cw_rqv2", 64'(bus.req_valid), 64'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b0;
    tick();
    chk("cw_ack3", 64'(bus.wb_ack_o),  64'd0);
    chk("cw_idle", 64'(o_state),       64'd0);
    chk("cw_dato", 64'(bus.wb_dat_o),  64'd0);

    // classic read with 3-cycle backend delay: ack at cycle 5
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h20; bus.wb_sel_i = 4'hF;
    tick();
    chk("cr_rqv",  64'(bus.req_valid), 64'd1);
    chk("cr_we",   64'(bus.req_we),    64'd0);
    chk("cr_adr",  64'(bus.req_adr),   64'h20);
    tick();
    tick();
    chk("cr_ack3", 64'(bus.wb_ack_o),  64'd0);
    tick();
    chk("cr_ack4", 64'(bus.wb_ack_o),  64'd0);
    bus.rsp_valid = 1'b1; bus.rsp_dat = 32'h1234_5678;
    tick();
    chk("cr_ack5", 64'(bus.wb_ack_o),  64'd1);
    chk("cr_dato", 64'(bus.wb_dat_o),  64'h1234_5678);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b0;
    tick();
    chk("cr_ack6", 64'(bus.wb_ack_o),  64'd0);
    chk("cr_hold", 64'(bus.wb_dat_o),  64'h1234_5678);

    // wrap-4 read burst from 0x1C, last beat flagged with cti 111
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h1C; bus.wb_cti_i = 3'b010; bus.wb_bte_i = 2'b01;
    bus.rsp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) bus.wb_cti_i = 3'b111;
      bus.rsp_dat = 32'hC0DE_0000 + 32'(k);
      chk($sformatf("wr_adr%0d", k), 64'(bus.req_adr),   64'(wrap_adr[k]));
      chk($sformatf("wr_bst%0d", k), 64'(bus.req_burst), 64'd1);
      tick();
      chk($sformatf("wr_ack%0d", k), 64'(bus.wb_ack_o),  64'd1);
      chk($sformatf("wr_dat%0d", k), 64'(bus.wb_dat_o),  64'(32'hC0DE_0000 + 32'(k)));
    end
    tick();
    chk("wr_idle", 64'(o_state),       64'd0);
    chk("wr_rqv",  64'(bus.req_valid), 64'd0);
    chk("wr_ack",  64'(bus.wb_ack_o),  64'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b0;
    tick();

    // linear write burst from 0x100, data/mask resampled per beat
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 32'h100; bus.wb_cti_i = 3'b010; bus.wb_bte_i = 2'b00;
    bus.wb_dat_i = lin_dat[0]; bus.wb_sel_i = lin_sel[0]; bus.rsp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) bus.wb_cti_i = 3'b111;
      chk($sformatf("ln_adr%0d", k), 64'(bus.req_adr),  64'(32'h100 + 32'(4 * k)));
      chk($sformatf("ln_dat%0d", k), 64'(bus.req_dat),  64'(lin_dat[k]));
      chk($sformatf("ln_msk%0d", k), 64'(bus.req_mask), 64'(lin_sel[k]));
      tick();
      if (bus.wb_ack_o) ack_cnt++;
      chk($sformatf("ln_dato%0d", k), 64'(bus.wb_dat_o), 64'hC0DE_0003);
      if (k < 3) begin
        bus.wb_dat_i = lin_dat[k + 1];
        bus.wb_sel_i = lin_sel[k + 1];
      end
    end
    chk("ln_acks", 64'(ack_cnt), 64'd4);
    tick();
    chk("ln_idle", 64'(o_state), 64'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b0;
    tick();

    // error on the second beat of a linear read burst ends the burst
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h200; bus.wb_cti_i = 3'b010; bus.wb_bte_i = 2'b00;
    bus.rsp_valid = 1'b1;
    tick();
    chk("er_adr0", 64'(bus.req_adr),  64'h200);
    tick();
    chk("er_ack0", 64'(bus.wb_ack_o), 64'd1);
    tick();
    chk("er_adr1", 64'(bus.req_adr),  64'h204);
    bus.rsp_err = 1'b1;
    tick();
    chk("er_err1", 64'(bus.wb_err_o), 64'd1);
    chk("er_ack1", 64'(bus.wb_ack_o), 64'd0);
    chk("er_rty1", 64'(bus.wb_rty_o), 64'd0);
    bus.rsp_err = 1'b0;
    tick();
    chk("er_err2", 64'(bus.wb_err_o),  64'd0);
    chk("er_idle", 64'(o_state),       64'd0);
    chk("er_rqv",  64'(bus.req_valid), 64'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b0;
    tick();

    // retry response on a classic read
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h280; bus.wb_cti_i = 3'b000;
    bus.rsp_valid = 1'b1; bus.rsp_rty = 1'b1;
    tick();
    tick();
`ifdef MSI_WB_BFM_SLAVE_RTY_EN
    chk("rt_rty", 64'(bus.wb_rty_o), 64'd1);
    chk("rt_ack", 64'(bus.wb_ack_o), 64'd0);
`else
    chk("rt_rty", 64'(bus.wb_rty_o), 64'd0);
    chk("rt_ack", 64'(bus.wb_ack_o), 64'd1);
`endif
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rty = 1'b0;
    tick();
    chk("rt_rty2", 64'(bus.wb_rty_o), 64'd0);
    chk("rt_idle", 64'(o_state),      64'd0);

    // cyc dropped in REQ; a coincident rsp_valid is ignored
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h300;
    tick();
    chk("ab_rqv1", 64'(bus.req_valid), 64'd1);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b1;
    tick();
    chk("ab_rqv2", 64'(bus.req_valid), 64'd0);
    chk("ab_ack",  64'(bus.wb_ack_o),  64'd0);
    chk("ab_err",  64'(bus.wb_err_o),  64'd0);
    chk("ab_idle", 64'(o_state),       64'd0);
    bus.rsp_valid = 1'b0;
    tick();
    chk("ab_ack2", 64'(bus.wb_ack_o),  64'd0);

    // reset in the middle of a beat
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
    bus.wb_adr_i = 32'h400; bus.wb_dat_i = 32'h55AA_55AA; bus.wb_sel_i = 4'hF;
    tick();
    chk("mr_rqv", 64'(bus.req_valid), 64'd1);
    i_rst_n = 1'b0; bus.rsp_valid = 1'b1;
    tick();
    chk_reset_vals("mr");
    i_rst_n = 1'b1; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b0;
    tick();

    // constant-address burst holds the address
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 32'h40; bus.wb_cti_i = 3'b001; bus.wb_bte_i = 2'b00;
    bus.rsp_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (k == 1) bus.wb_cti_i = 3'b111;
      chk($sformatf("ca_adr%0d", k), 64'(bus.req_adr),  64'h40);
      tick();
      chk($sformatf("ca_ack%0d", k), 64'(bus.wb_ack_o), 64'd1);
    end
    tick();
    chk("ca_idle", 64'(o_state), 64'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.rsp_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
